// File: rtl/l2_word_responder_pkg.sv
// Shared torrence types: the memory request opcodes driven by the L1
// controllers, the L2 responder state encoding, and the LFSR seed used
// when L2_RESPONDER_JITTER_EN is defined.
package torrence_types;

   typedef enum logic [1:0] {
      LOAD       = 2'b00,
      STORE      = 2'b01,
      CLFLUSH    = 2'b10,
      MO_UNKNOWN = 2'b11
   } memory_operation_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_WAIT    = 2'b01,
      ST_RESPOND = 2'b10,
      ST_RECOVER = 2'b11,
      ST_UNKNOWN = 2'bxx
   } l2_responder_state_e;

   localparam logic [3:0] L2_JITTER_LFSR_SEED = 4'b1001;

endpackage

// File: rtl/l2_word_responder_array.sv
// Word-addressed backing store for the L2 responder: synchronous write,
// combinational read, contents intentionally left unreset.
module l2_word_array #(
   parameter int XLEN      = 32,
   parameter int MEM_WORDS = 1024,
   localparam int IDX_W    = $clog2(MEM_WORDS)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_addr,
   input  logic [XLEN-1:0]  i_wdata,
   output logic [XLEN-1:0]  o_rdata
);

   logic [XLEN-1:0] r_mem [MEM_WORDS];

   // Commit a store on the clock edge the responder leaves its respond state.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/l2_word_responder.sv
// L2-side responder for the word-serial request/fulfil handshake.
// Accepts one word at a time, waits LATENCY cycles, pulses req_fulfilled
// for one cycle, then spends one dead cycle before accepting again.
// Optional macro L2_RESPONDER_JITTER_EN adds 0..3 extra wait cycles per
// request, drawn from a 4-bit LFSR (x^4+x^3+1).
module l2_word_responder
   import torrence_types::*;
#(
   parameter int XLEN      = 32,
   parameter int ADDR_W    = 32,
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   input  memory_operation_e req_type,
   input  logic [ADDR_W-1:0] req_address,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              req_fulfilled,
   output logic [XLEN-1:0]   req_rdata,
   output logic              req_error,
   output logic              busy
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

   l2_responder_state_e r_state;
   l2_responder_state_e w_next;
   logic [4:0]          r_count;
   logic [4:0]          w_countNext;
   logic [4:0]          w_loadCount;
   logic [4:0]          w_jitter;
   logic                w_accept;
   logic                w_we;
   memory_operation_e   r_type;
   logic [IDX_W-1:0]    r_idx;
   logic [XLEN-1:0]     r_wdata;
   logic [XLEN-1:0]     w_arrayRdata;
   logic                w_unused;

   assign w_unused = ^{req_address[ADDR_W-1:IDX_W+2], req_address[1:0]};

`ifdef L2_RESPONDER_JITTER_EN
   logic [3:0] r_lfsr;

   // Free-running LFSR; its low two bits become extra wait cycles at accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lfsr <= L2_JITTER_LFSR_SEED;
      end else begin
         r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
      end
   end

   assign w_jitter = {3'b000, r_lfsr[1:0]};
`else
   assign w_jitter = 5'd0;
`endif

   assign w_loadCount = LAT_M1 + w_jitter;

   // State and latency counter; reset drops any in-flight request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_count <= 5'd0;
      end else begin
         r_state <= w_next;
         r_count <= w_countNext;
      end
   end

   // Capture the request fields once at accept so later input churn is ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_type  <= LOAD;
         r_idx   <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_type  <= req_type;
         r_idx   <= req_address[IDX_W+1:2];
         r_wdata <= req_wdata;
      end
   end

   // Next-state, counter and Moore outputs for the handshake.
   always_comb begin
      w_next        = r_state;
      w_countNext   = r_count;
      w_accept      = 1'b0;
      w_we          = 1'b0;
      req_fulfilled = 1'b0;
      req_rdata     = '0;
      req_error     = 1'b0;
      busy          = 1'b1;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (req_valid) begin
               w_accept    = 1'b1;
               w_countNext = w_loadCount;
               w_next      = (w_loadCount == 5'd0) ? ST_RESPOND : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!req_valid) begin
               w_next      = ST_IDLE;
               w_countNext = 5'd0;
            end else if (r_count <= 5'd1) begin
               w_next      = ST_RESPOND;
               w_countNext = 5'd0;
            end else begin
               w_countNext = r_count - 5'd1;
            end
         end
         ST_RESPOND: begin
            req_fulfilled = 1'b1;
            w_next        = ST_RECOVER;
            case (r_type)
               LOAD:    req_rdata = w_arrayRdata;
               STORE:   w_we      = 1'b1;
               CLFLUSH: ;
               default: req_error = 1'b1;
            endcase
         end
         ST_RECOVER: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next        = ST_UNKNOWN;
            w_countNext   = 'x;
            w_we          = 1'bx;
            req_fulfilled = 1'bx;
            req_rdata     = 'x;
            req_error     = 1'bx;
            busy          = 1'bx;
         end
      endcase
   end

   l2_word_array #(
      .XLEN      (XLEN),
      .MEM_WORDS (MEM_WORDS)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (r_idx),
      .i_wdata (r_wdata),
      .o_rdata (w_arrayRdata)
   );

endmodule

// File: tb/tb_l2_word_responder.sv
// Self-checking bench for l2_word_responder. A word-indexed associative
// array models the backing store; latency and pulse spacing come from the
// handshake rules (LATENCY, plus 0..3 when L2_RESPONDER_JITTER_EN is set).
module tb_l2_word_responder;
   import torrence_types::*;

   localparam int LAT   = 4;
   localparam int WORDS = 1024;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              req_valid;
   memory_operation_e req_type;
   logic [31:0]       req_address;
   logic [31:0]       req_wdata;
   logic              req_fulfilled;
   logic [31:0]       req_rdata;
   logic              req_error;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   logic [31:0] model [int];
   logic [31:0] written [$];

   l2_word_responder #(
      .XLEN(32), .ADDR_W(32), .MEM_WORDS(WORDS), .LATENCY(LAT)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_type      (req_type),
      .req_address   (req_address),
      .req_wdata     (req_wdata),
      .req_fulfilled (req_fulfilled),
      .req_rdata     (req_rdata),
      .req_error     (req_error),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int wordIdx(input logic [31:0] a);
      return int'((a >> 2) % WORDS);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkLatency(input string tag, input int n, input int base);
`ifdef L2_RESPONDER_JITTER_EN
      checkOutput(tag, 32'((n >= base) && (n <= base + 3)), 32'd1);
`else
      checkOutput(tag, 32'(n), 32'(base));
`endif
   endtask

   task automatic applyStimulus(input logic v, input memory_operation_e t,
                                input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req_valid   = v;
      req_type    = t;
      req_address = a;
      req_wdata   = d;
   endtask

   task automatic waitFulfil(output int n, output bit seen);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (req_fulfilled === 1'b1) seen = 1'b1;
      end
   endtask

   // Expected result of one word and model update.
   task automatic checkResult(input string tag, input memory_operation_e t,
                              input logic [31:0] a, input logic [31:0] d);
      logic [31:0] expR;
      expR = 32'd0;
      if (t == LOAD) expR = model.exists(wordIdx(a)) ? model[wordIdx(a)] : 32'd0;
      checkOutput({tag, " rdata"}, req_rdata, expR);
      checkOutput({tag, " error"}, 32'(req_error), 32'(t == MO_UNKNOWN));
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      if (t == STORE) begin
         model[wordIdx(a)] = d;
         written.push_back(a);
      end
   endtask

   task automatic doWord(input string tag, input memory_operation_e t,
                         input logic [31:0] a, input logic [31:0] d);
      int n;
      bit seen;
      applyStimulus(1'b1, t, a, d);
      waitFulfil(n, seen);
      checkOutput({tag, " seen"}, 32'(seen), 32'd1);
      checkLatency({tag, " latency"}, n, LAT);
      checkResult(tag, t, a, d);
      applyStimulus(1'b0, LOAD, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, " pulse"}, 32'(req_fulfilled), 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   // Several words with req_valid held high; fields advance after each pulse.
   task automatic heldSequence(input string tag, input memory_operation_e t[4],
                               input logic [31:0] a[4], input logic [31:0] d[4],
                               input int count);
      int n;
      bit seen;
      int prev;
      prev = 0;
      applyStimulus(1'b1, t[0], a[0], d[0]);
      for (int k = 0; k < count; k++) begin
         waitFulfil(n, seen);
         checkOutput($sformatf("%s w%0d seen", tag, k), 32'(seen), 32'd1);
         if (k == 0) checkLatency($sformatf("%s w0 latency", tag), n, LAT);
         else checkLatency($sformatf("%s w%0d spacing", tag, k), cycle - prev, LAT + 2);
         prev = cycle;
         checkResult($sformatf("%s w%0d", tag, k), t[k], a[k], d[k]);
         if (k < count - 1) applyStimulus(1'b1, t[k+1], a[k+1], d[k+1]);
         else applyStimulus(1'b0, LOAD, 32'd0, 32'd0);
      end
      @(posedge clk);
      #1;
      checkOutput({tag, " pulse"}, 32'(req_fulfilled), 32'd0);
      @(posedge clk);
      #1;
      checkOutput({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      memory_operation_e ts[4];
      logic [31:0] as[4];
      logic [31:0] ds[4];
      bit anyPulse;

      reset_n     = 1'b0;
      req_valid   = 1'b0;
      req_type    = LOAD;
      req_address = 32'd0;
      req_wdata   = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset fulfilled", 32'(req_fulfilled), 32'd0);
      checkOutput("reset rdata", req_rdata, 32'd0);
      checkOutput("reset error", 32'(req_error), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] basic load");
      doWord("store10", STORE, 32'h10, 32'hDEADBEEF);
      doWord("load10", LOAD, 32'h10, 32'h0);

      $display("[TB] back-to-back store/load");
      ts = '{STORE, LOAD, LOAD, LOAD};
      as = '{32'h20, 32'h20, 32'h0, 32'h0};
      ds = '{32'hCAFEF00D, 32'h0, 32'h0, 32'h0};
      heldSequence("b2b", ts, as, ds, 2);

      $display("[TB] line fill");
      ts = '{STORE, STORE, STORE, STORE};
      as = '{32'h40, 32'h44, 32'h48, 32'h4C};
      ds = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
      heldSequence("fillst", ts, as, ds, 4);
      ts = '{LOAD, LOAD, LOAD, LOAD};
      heldSequence("fill", ts, as, ds, 4);

      $display("[TB] abort");
      doWord("abortpre", STORE, 32'h80, 32'h11111111);
      applyStimulus(1'b1, STORE, 32'h80, 32'h22222222);
      @(posedge clk);
      #1;
      checkOutput("abort c1 fulfilled", 32'(req_fulfilled), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("abort c2 fulfilled", 32'(req_fulfilled), 32'd0);
      applyStimulus(1'b0, LOAD, 32'd0, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("abort idle", 32'(busy), 32'd0);
      anyPulse = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (req_fulfilled !== 1'b0) anyPulse = 1'b1;
      end
      checkOutput("abort no pulse", 32'(anyPulse), 32'd0);
      doWord("abortld", LOAD, 32'h80, 32'h0);

      $display("[TB] unknown and clflush");
      doWord("unknown", MO_UNKNOWN, 32'h80, 32'h33333333);
      doWord("clflush", CLFLUSH, 32'h80, 32'h44444444);
      doWord("postflush", LOAD, 32'h80, 32'h0);

      $display("[TB] reset during wait");
      doWord("rstpre", STORE, 32'h84, 32'h12345678);
      applyStimulus(1'b1, STORE, 32'h84, 32'h55555555);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("midrst fulfilled", 32'(req_fulfilled), 32'd0);
      checkOutput("midrst busy", 32'(busy), 32'd0);
      checkOutput("midrst rdata", req_rdata, 32'd0);
      checkOutput("midrst error", 32'(req_error), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      reset_n   = 1'b1;
      doWord("rstld", LOAD, 32'h84, 32'h0);

      $display("[TB] randomized words");
      for (int i = 0; i < 40; i++) begin
         int op;
         logic [31:0] a;
         logic [31:0] d;
         op = int'($urandom_range(0, 3));
         d  = $urandom;
         if (op == 0) begin
            a = written[$urandom_range(0, written.size() - 1)];
            a = {a[31:12] ^ 20'($urandom), a[11:2], 2'($urandom)};
            doWord($sformatf("rnd%0d load", i), LOAD, a, d);
         end else if (op == 1) begin
            a = $urandom;
            doWord($sformatf("rnd%0d store", i), STORE, a, d);
         end else if (op == 2) begin
            a = written[$urandom_range(0, written.size() - 1)];
            doWord($sformatf("rnd%0d flush", i), CLFLUSH, a, d);
         end else begin
            a = $urandom;
            doWord($sformatf("rnd%0d unknown", i), MO_UNKNOWN, a, d);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/l2_word_responder.md
Name: l2_word_responder

Overview:
- L2-side responder for the word-serial request/fulfil handshake that the L1 cache controllers drive.
- Accepts one word request at a time (LOAD, STORE, CLFLUSH) and waits a fixed access latency.
- Then pulses req_fulfilled for one cycle, returning read data or committing store data to a word-addressed backing array.
- Serves as the L2 model under the icache/dcache benches and as the skeleton for the real L2 front end.

Parameters:
- XLEN, 32, data word width in bits.
- ADDR_W, 32, request byte-address width.
- MEM_WORDS, 1024, backing array depth in words; power of two.
- LATENCY, 4, cycles from accept to fulfil; legal range 1..15.

Ports:
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request pending; held high across a multi-word line fill
- req_type  input  memory_operation_e  LOAD / STORE / CLFLUSH / MO_UNKNOWN
- req_address  input  ADDR_W  byte address of the current word
- req_wdata  input  XLEN  store data
- req_fulfilled  output  1  one-cycle pulse: current word done
- req_rdata  output  XLEN  load data, valid only while req_fulfilled=1
- req_error  output  1  one-cycle pulse alongside req_fulfilled for MO_UNKNOWN or X type
- busy  output  1  high in any state other than ST_IDLE

Behaviour:
- States: ST_IDLE, ST_WAIT, ST_RESPOND, ST_RECOVER.
- Async reset: state=ST_IDLE, latency counter=0, req_fulfilled=0, req_rdata=0, req_error=0, busy=0.
- Backing array contents are not reset.
- ST_IDLE:
  - If req_valid=1, latch type, address and wdata; counter=LATENCY-1.
  - If LATENCY==1, go to ST_RESPOND; otherwise go to ST_WAIT.
- ST_WAIT:
  - Decrement the counter each cycle; when counter==1, go to ST_RESPOND.
  - If req_valid drops, abort: go to ST_IDLE, no write, no fulfil.
- ST_RESPOND (Moore outputs): req_fulfilled=1.
  - LOAD: req_rdata=mem[idx].
  - STORE: mem[idx]<=latched wdata at this edge; req_rdata=0.
  - CLFLUSH: no array change; req_rdata=0.
  - MO_UNKNOWN: req_error=1; no array change.
  - Always go to ST_RECOVER.
- ST_RECOVER:
  - One dead cycle with fulfilled=0 and inputs ignored.
  - Gives the requester time to advance its word address/counter.
  - Then go to ST_IDLE.
- Timing: req_valid sampled at edge T gives req_fulfilled high during cycle T+LATENCY.
- Back-to-back words under continuous req_valid are spaced LATENCY+2 cycles apart.
- Indexing: idx = latched_address[$clog2(MEM_WORDS)+1:2].
  - Address bits [1:0] are ignored.
  - Upper bits alias (wrap) silently.
- Request fields are latched at accept; later changes to address/wdata/type during ST_WAIT have no effect.
- reset_n asserted mid-operation: immediate return to ST_IDLE, any pending store is dropped, outputs go to reset values.
- Unreachable state: next state and outputs are driven to X.

Optional Feature:
- Macro L2_RESPONDER_JITTER_EN.
- Defined:
  - A 4-bit LFSR (x^4+x^3+1, seed 4'b1001 on reset) advances every cycle.
  - At accept, its low two bits (0..3) are added as extra ST_WAIT cycles.
  - Latency therefore ranges over LATENCY..LATENCY+3.
- Undefined: latency is exactly LATENCY and no LFSR exists.

Decomposition:
- Reuse memory_operation_e from torrence_types.
- Add to torrence_types:
  - l2_responder_state_e (2-bit encodings, with an unknown member).
  - L2_JITTER_LFSR_SEED constant.
- One natural sub-module: l2_word_array (synchronous-write, combinational-read word RAM, parameterised on XLEN and MEM_WORDS).

Test Plan:
- Reset, then LOAD to addr 0x10 with mem[4]=0xDEADBEEF → fulfilled exactly at cycle 4 after accept, rdata=0xDEADBEEF, one-cycle pulse, busy low again 2 cycles later.
- STORE 0xCAFEF00D to 0x20, then LOAD 0x20 → second fulfil returns 0xCAFEF00D; with LATENCY=4, the two fulfils are 6 cycles apart.
- 4-word line fill with req_valid held high and address stepping 0x40/44/48/4C after each fulfil → 4 pulses, each returning the correct word, no duplicate or skipped words.
- req_valid dropped at cycle 2 of a STORE → no fulfil, mem unchanged, state ST_IDLE next cycle.
- req_type=MO_UNKNOWN → req_fulfilled and req_error both high for one cycle; CLFLUSH → fulfilled, error low, mem unchanged.
- reset_n pulsed low during ST_WAIT of a STORE → outputs zero immediately, store not committed. With JITTER_EN, 100 LOADs all land within LATENCY..LATENCY+3 cycles.
